// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs bytes little-endian into
// WIDTH-bit words, writes them from address 0 and holds the core in reset until done.
module imem_loader #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WIDTH-1:0]  imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int BYTES = WIDTH / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [BI_W-1:0]   byte_idx_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [WIDTH-1:0]  asm_q, asm_d;
  logic              last_q;
  logic              accept;
  logic              word_end;

  assign accept   = s_valid && s_ready && (state_q == S_LOAD);
  assign word_end = accept && ((byte_idx_q == LAST_BYTE) || s_last);

  // Assembly register with the byte accepted this cycle already merged in, so
  // the write data can be captured on the same edge that takes the last byte.
  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < BYTES; k++) begin
      if (accept && (byte_idx_q == BI_W'(k))) asm_d[8*k +: 8] = s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LOAD;
      S_LOAD:                  if (word_end) state_d = S_WRITE;
      S_WRITE: begin
        if (last_q)                        state_d = S_DONE;
        else if (word_idx_q == LAST_WORD) state_d = S_ERROR;
        else                               state_d = S_LOAD;
      end
      default:                 state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      asm_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      // Status outputs are registered copies of the next state.
      s_ready  <= (state_d == S_LOAD);
      imem_we  <= (state_d == S_WRITE);
      done     <= (state_d == S_DONE);
      err      <= (state_d == S_ERROR);
      core_rst <= (state_d != S_DONE);

      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            byte_idx_q <= '0;
            word_idx_q <= '0;
            word_count <= '0;
            asm_q      <= '0;
            last_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (word_end) begin
            imem_addr  <= word_idx_q;
            imem_wdata <= asm_d;
            word_count <= word_count + (ADDR_W+1)'(1);
            last_q     <= s_last;
            byte_idx_q <= '0;
            asm_q      <= '0;
          end else if (accept) begin
            byte_idx_q <= byte_idx_q + BI_W'(1);
            asm_q      <= asm_d;
          end
        end
        S_WRITE: begin
          if (!last_q && (word_idx_q != LAST_WORD)) word_idx_q <= word_idx_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default instance for normal loads, ADDR_W=2
// instance for capacity overflow; writes are logged by a negedge monitor.
module tb_imem_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst, start, s_valid, s_last, sel;
  logic [7:0] s_data;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  wr_t log1[$];
  wr_t log2[$];

  logic        s_ready1, we1, core_rst1, done1, err1;
  logic [7:0]  addr1;
  logic [31:0] wdata1;
  logic [8:0]  wc1;
  logic        s_ready2, we2, core_rst2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  wc2;
  logic        rdy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rdy = sel ? s_ready2 : s_ready1;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start & ~sel), .s_valid(s_valid & ~sel),
    .s_data(s_data), .s_last(s_last), .s_ready(s_ready1), .imem_we(we1),
    .imem_addr(addr1), .imem_wdata(wdata1), .core_rst(core_rst1),
    .done(done1), .err(err1), .word_count(wc1)
  );

  imem_loader #(.WIDTH(32), .ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start & sel), .s_valid(s_valid & sel),
    .s_data(s_data), .s_last(s_last), .s_ready(s_ready2), .imem_we(we2),
    .imem_addr(addr2), .imem_wdata(wdata2), .core_rst(core_rst2),
    .done(done2), .err(err2), .word_count(wc2)
  );

  // Write monitor: logs every write and requires s_ready low while writing.
  always @(negedge clk) begin
    if (we1 === 1'b1) begin
      log1.push_back('{addr: addr1, data: wdata1, cyc: cyc});
      checks++;
      if (s_ready1 !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write1: s_ready=%b want 0", s_ready1);
      end
    end
    if (we2 === 1'b1) begin
      log2.push_back('{addr: {6'b0, addr2}, data: wdata2, cyc: cyc});
      checks++;
      if (s_ready2 !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write2: s_ready=%b want 0", s_ready2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte and returns the cycle number of the edge that took it.
  task automatic send_byte(input logic [7:0] d, input logic last, output int acc);
    bit ok = 0;
    acc = -1;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (rdy === 1'b1) begin
        @(posedge clk);
        ok = 1;
        @(negedge clk);
        acc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL handshake: byte %h not accepted within 40 cycles", d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; sel = 1'b0;
    repeat (2) @(negedge clk);
    checks += 8;
    if (core_rst1 !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", core_rst1); end
    if (s_ready1 !== 1'b0)  begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready1); end
    if (done1 !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done1); end
    if (err1 !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b want 0", err1); end
    if (we1 !== 1'b0)       begin errors++; $display("FAIL reset_we: got %b want 0", we1); end
    if (wc1 !== 9'd0)       begin errors++; $display("FAIL reset_word_count: got %0d want 0", wc1); end
    if (addr1 !== 8'd0 || wdata1 !== 32'd0) begin
      errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", addr1, wdata1);
    end
    if (core_rst2 !== 1'b1 || err2 !== 1'b0) begin
      errors++; $display("FAIL reset_dut2: core_rst=%b err=%b want 1/0", core_rst2, err2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_word();
    logic [7:0] b[8] = '{8'h93, 8'h80, 8'hA0, 8'h00, 8'h13, 8'h01, 8'hA1, 8'h00};
    int acc[8];
    sel = 1'b0;
    pulse_start();
    log1.delete();
    for (int i = 0; i < 8; i++) send_byte(b[i], i == 7, acc[i]);
    tick(3);
    checks++;
    if (log1.size() != 2) begin
      errors++; $display("FAIL two_word_count: got %0d writes want 2", log1.size());
    end else begin
      checks += 2;
      if (log1[0].addr !== 8'd0 || log1[0].data !== 32'h00A08093 || log1[0].cyc != acc[3]) begin
        errors++;
        $display("FAIL two_word_w0: got addr=%0d data=%h cyc=%0d want 0/00a08093/%0d",
                 log1[0].addr, log1[0].data, log1[0].cyc, acc[3]);
      end
      if (log1[1].addr !== 8'd1 || log1[1].data !== 32'h00A10113 || log1[1].cyc != acc[7]) begin
        errors++;
        $display("FAIL two_word_w1: got addr=%0d data=%h cyc=%0d want 1/00a10113/%0d",
                 log1[1].addr, log1[1].data, log1[1].cyc, acc[7]);
      end
    end
    checks++;
    if (done1 !== 1'b1 || core_rst1 !== 1'b0 || wc1 !== 9'd2) begin
      errors++;
      $display("FAIL two_word_done: done=%b core_rst=%b wc=%0d want 1/0/2", done1, core_rst1, wc1);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[8]   = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    int         gap[8] = '{1, 0, 2, 0, 1, 2, 0, 0};
    int acc[8];
    sel = 1'b0;
    pulse_start();
    log1.delete();
    for (int i = 0; i < 8; i++) begin
      send_byte(b[i], i == 7, acc[i]);
      for (int g = 0; g < gap[i]; g++) begin
        checks++;
        if (s_ready1 !== 1'b1) begin
          errors++; $display("FAIL bp_ready_gap: byte %0d gap %0d s_ready=%b want 1", i, g, s_ready1);
        end
        tick(1);
      end
    end
    tick(3);
    checks++;
    if (acc[4] != acc[3] + 2) begin
      errors++; $display("FAIL bp_write_stall: byte4 taken at %0d want %0d", acc[4], acc[3] + 2);
    end
    checks++;
    if (log1.size() != 2) begin
      errors++; $display("FAIL bp_count: got %0d writes want 2", log1.size());
    end else begin
      checks += 2;
      if (log1[0].addr !== 8'd0 || log1[0].data !== 32'hDEADBEEF) begin
        errors++; $display("FAIL bp_w0: got %0d/%h want 0/deadbeef", log1[0].addr, log1[0].data);
      end
      if (log1[1].addr !== 8'd1 || log1[1].data !== 32'h12345678) begin
        errors++; $display("FAIL bp_w1: got %0d/%h want 1/12345678", log1[1].addr, log1[1].data);
      end
    end
    checks++;
    if (done1 !== 1'b1 || wc1 !== 9'd2) begin
      errors++; $display("FAIL bp_done: done=%b wc=%0d want 1/2", done1, wc1);
    end
  endtask

  task automatic test_partial();
    int acc;
    sel = 1'b0;
    pulse_start();
    log1.delete();
    send_byte(8'hAA, 1'b0, acc);
    send_byte(8'hBB, 1'b0, acc);
    send_byte(8'hCC, 1'b1, acc);
    tick(3);
    checks++;
    if (log1.size() != 1) begin
      errors++; $display("FAIL partial_count: got %0d writes want 1", log1.size());
    end else begin
      checks++;
      if (log1[0].addr !== 8'd0 || log1[0].data !== 32'h00CCBBAA || log1[0].cyc != acc) begin
        errors++;
        $display("FAIL partial_w0: got %0d/%h cyc=%0d want 0/00ccbbaa cyc=%0d",
                 log1[0].addr, log1[0].data, log1[0].cyc, acc);
      end
    end
    checks++;
    if (done1 !== 1'b1 || core_rst1 !== 1'b0 || wc1 !== 9'd1) begin
      errors++;
      $display("FAIL partial_done: done=%b core_rst=%b wc=%0d want 1/0/1", done1, core_rst1, wc1);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w[4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    int acc;
    sel = 1'b1;
    pulse_start();
    log2.delete();
    for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 1'b0, acc);
    tick(2);
    checks++;
    if (log2.size() != 4) begin
      errors++; $display("FAIL ovf_count: got %0d writes want 4", log2.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        checks++;
        if (log2[w].addr !== 8'(w) || log2[w].data !== exp_w[w]) begin
          errors++;
          $display("FAIL ovf_w%0d: got %0d/%h want %0d/%h", w, log2[w].addr, log2[w].data, w, exp_w[w]);
        end
      end
    end
    checks++;
    if (err2 !== 1'b1 || s_ready2 !== 1'b0 || core_rst2 !== 1'b1 || wc2 !== 3'd4 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_err: err=%b s_ready=%b core_rst=%b wc=%0d done=%b want 1/0/1/4/0",
               err2, s_ready2, core_rst2, wc2, done2);
    end
    s_valid = 1'b1;
    s_data  = 8'h55;
    tick(4);
    s_valid = 1'b0;
    checks++;
    if (log2.size() != 4 || s_ready2 !== 1'b0) begin
      errors++; $display("FAIL ovf_blocked: writes=%0d s_ready=%b want 4/0", log2.size(), s_ready2);
    end
    pulse_start();
    checks++;
    if (err2 !== 1'b0 || s_ready2 !== 1'b1) begin
      errors++; $display("FAIL ovf_restart: err=%b s_ready=%b want 0/1", err2, s_ready2);
    end
    log2.delete();
    send_byte(8'h11, 1'b0, acc);
    send_byte(8'h22, 1'b0, acc);
    send_byte(8'h33, 1'b0, acc);
    send_byte(8'h44, 1'b1, acc);
    tick(3);
    checks++;
    if (log2.size() != 1 || done2 !== 1'b1) begin
      errors++; $display("FAIL ovf_reload: writes=%0d done=%b want 1/1", log2.size(), done2);
    end else begin
      checks++;
      if (log2[0].addr !== 8'd0 || log2[0].data !== 32'h44332211) begin
        errors++; $display("FAIL ovf_reload_w0: got %0d/%h want 0/44332211", log2[0].addr, log2[0].data);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reload_reset();
    int acc;
    sel = 1'b0;
    pulse_start();
    checks++;
    if (core_rst1 !== 1'b1 || done1 !== 1'b0 || s_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reload_start: core_rst=%b done=%b s_ready=%b want 1/0/1", core_rst1, done1, s_ready1);
    end
    log1.delete();
    send_byte(8'hC0, 1'b0, acc);
    send_byte(8'hFF, 1'b0, acc);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (s_ready1 !== 1'b0 || core_rst1 !== 1'b1 || wc1 !== 9'd0) begin
      errors++;
      $display("FAIL async_reset: s_ready=%b core_rst=%b wc=%0d want 0/1/0", s_ready1, core_rst1, wc1);
    end
    @(negedge clk);
    tick(1);
    rst = 1'b0;
    tick(3);
    checks++;
    if (log1.size() != 0 || s_ready1 !== 1'b0 || done1 !== 1'b0 || core_rst1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: writes=%0d s_ready=%b done=%b core_rst=%b want 0/0/0/1",
               log1.size(), s_ready1, done1, core_rst1);
    end
    pulse_start();
    send_byte(8'h11, 1'b0, acc);
    send_byte(8'h22, 1'b0, acc);
    send_byte(8'h33, 1'b0, acc);
    send_byte(8'h44, 1'b1, acc);
    tick(3);
    checks++;
    if (log1.size() != 1) begin
      errors++; $display("FAIL after_reset_count: got %0d writes want 1", log1.size());
    end else begin
      checks++;
      if (log1[0].addr !== 8'd0 || log1[0].data !== 32'h44332211) begin
        errors++; $display("FAIL after_reset_w0: got %0d/%h want 0/44332211", log1[0].addr, log1[0].data);
      end
    end
    checks++;
    if (done1 !== 1'b1 || wc1 !== 9'd1) begin
      errors++; $display("FAIL after_reset_done: done=%b wc=%0d want 1/1", done1, wc1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; sel = 1'b0;
    @(negedge clk);
    test_reset();
    test_two_word();
    test_backpressure();
    test_partial();
    test_overflow();
    test_reload_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
